// File: rtl/ref_level_tracker.sv
// Adaptive 4-PAM reference-level tracker: windowed mean of |dec_var| drives the
// slicer thresholds, alongside a windowed mean-squared decision error.
module ref_level_tracker #(
    parameter int                 LOG2_N   = 10,
    parameter logic signed [17:0] INIT_REF = 18'sd32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_en,
    input  logic               freeze,
    input  logic signed [17:0] dec_var,
    input  logic signed [17:0] out_map_out,
    output logic signed [17:0] ref_level,
    output logic        [17:0] err_power,
    output logic               update,
    output logic               locked
);

    localparam int ACC_W = 18 + LOG2_N;

    typedef enum logic {WARMUP, TRACK} state_t;

    state_t             state;
    logic               v1;
    logic        [17:0] abs_q;
    logic signed [17:0] e_q;
    logic [ACC_W-1:0]   acc_abs;
    logic [ACC_W-1:0]   acc_err;
    logic [LOG2_N-1:0]  cnt;

    logic        [17:0] abs_next;
    logic signed [18:0] diff;
    logic signed [17:0] e_next;
    logic signed [35:0] prod;
    logic        [35:0] sq_shift;
    logic        [17:0] sq;
    logic [ACC_W-1:0]   sum_abs;
    logic [ACC_W-1:0]   sum_err;
    logic               close;

    // Magnitude and error of the incoming symbol, both clamped into 1s17.
    always_comb begin
        abs_next = 18'd0;
        if (dec_var == -18'sd131072)
            abs_next = 18'd131071;
        else if (dec_var[17])
            abs_next = $unsigned(-dec_var);
        else
            abs_next = $unsigned(dec_var);

        diff   = {dec_var[17], dec_var} - {out_map_out[17], out_map_out};
        e_next = diff[17:0];
        case ({diff[18], diff[17]})
            2'b01:   e_next = 18'sh1FFFF;
            2'b10:   e_next = 18'sh20000;
            default: e_next = diff[17:0];
        endcase
    end

    always_comb begin
        prod     = e_q * e_q;
        sq_shift = $unsigned(prod) >> 17;
        sq       = (|sq_shift[35:18]) ? 18'h3FFFF : sq_shift[17:0];
        sum_abs  = acc_abs + {{LOG2_N{1'b0}}, abs_q};
        sum_err  = acc_err + {{LOG2_N{1'b0}}, sq};
        close    = v1 && (cnt == {LOG2_N{1'b1}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1    <= 1'b0;
            abs_q <= 18'd0;
            e_q   <= 18'sd0;
        end else begin
            v1 <= sym_en;
            if (sym_en) begin
                abs_q <= abs_next;
                e_q   <= e_next;
            end
        end
    end

    // Accumulation, window close and lock state; the closing sample is folded
    // into the published means in the same cycle it is absorbed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WARMUP;
            acc_abs   <= '0;
            acc_err   <= '0;
            cnt       <= '0;
            ref_level <= INIT_REF;
            err_power <= 18'd0;
            update    <= 1'b0;
            locked    <= 1'b0;
        end else begin
            update <= 1'b0;
            if (v1) begin
                if (close) begin
                    acc_abs   <= '0;
                    acc_err   <= '0;
                    cnt       <= '0;
                    err_power <= sum_err[ACC_W-1:LOG2_N];
                    update    <= 1'b1;
                    if (!freeze)
                        ref_level <= $signed(sum_abs[ACC_W-1:LOG2_N]);
                    case (state)
                        WARMUP: begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end
                        default: locked <= 1'b1;
                    endcase
                end else begin
                    acc_abs <= sum_abs;
                    acc_err <= sum_err;
                    cnt     <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ref_level_tracker.sv
// Scoreboard bench for ref_level_tracker with a 4-symbol window: a spec model
// queues expected window results, a monitor checks them on each update pulse.
module tb_ref_level_tracker;

    logic               clk;
    logic               reset;
    logic               sym_en;
    logic               freeze;
    logic signed [17:0] dec_var;
    logic signed [17:0] out_map_out;
    logic signed [17:0] ref_level;
    logic        [17:0] err_power;
    logic               update;
    logic               locked;

    typedef struct {
        longint refv;
        longint errv;
        longint lockv;
    } exp_t;

    exp_t   expQ[$];
    longint pulseCycles[$];
    int     errors = 0;
    int     checks = 0;
    int     pulseCount = 0;
    longint cycle = 0;

    longint mAccAbs, mAccErr, mRef;
    int     mCnt;

    ref_level_tracker #(.LOG2_N(2), .INIT_REF(18'sd32768)) dut (
        .clk(clk),
        .reset(reset),
        .sym_en(sym_en),
        .freeze(freeze),
        .dec_var(dec_var),
        .out_map_out(out_map_out),
        .ref_level(ref_level),
        .err_power(err_power),
        .update(update),
        .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic modelReset();
        mAccAbs = 0;
        mAccErr = 0;
        mCnt    = 0;
        mRef    = 32768;
        expQ.delete();
    endtask

    // Drives one symbol for one cycle, then gap idle cycles; called at posedge+1.
    task automatic applyStimulus(input int dv, input int mo, input int gap);
        longint a, e, sq;
        exp_t   x;
        a = (dv < 0) ? -longint'(dv) : longint'(dv);
        if (a > 131071) a = 131071;
        e = longint'(dv) - longint'(mo);
        if (e > 131071)  e = 131071;
        if (e < -131072) e = -131072;
        sq = (e * e) / 131072;
        mAccAbs += a;
        mAccErr += sq;
        mCnt++;
        if (mCnt == 4) begin
            if (!freeze) mRef = mAccAbs / 4;
            x.refv  = mRef;
            x.errv  = mAccErr / 4;
            x.lockv = 1;
            expQ.push_back(x);
            mAccAbs = 0;
            mAccErr = 0;
            mCnt    = 0;
        end
        sym_en      = 1'b1;
        dec_var     = dv[17:0];
        out_map_out = mo[17:0];
        @(posedge clk);
        #1;
        sym_en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ref"},    longint'(ref_level), 32768);
        checkOutput({tag, "_err"},    longint'(err_power), 0);
        checkOutput({tag, "_update"}, longint'(update),    0);
        checkOutput({tag, "_locked"}, longint'(locked),    0);
    endtask

    always @(negedge clk) begin
        if (!reset && update) begin
            exp_t x;
            pulseCount++;
            pulseCycles.push_back(cycle);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_update", 1, 0);
            end else begin
                x = expQ.pop_front();
                checkOutput("ref_level", longint'(ref_level), x.refv);
                checkOutput("err_power", longint'(err_power), x.errv);
                checkOutput("locked",    longint'(locked),    x.lockv);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int vals[4];
        int w;
        sym_en      = 1'b0;
        freeze      = 1'b0;
        dec_var     = '0;
        out_map_out = '0;
        reset       = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;
        waitCycles(1);

        // First window locks the tracker.
        repeat (4) applyStimulus(65536, 65536, 0);
        waitCycles(3);
        checkOutput("first_window_pulses", pulseCount, 1);

        vals = '{10, -20, 30, -41};
        foreach (vals[i]) applyStimulus(vals[i], vals[i], 0);
        waitCycles(3);

        repeat (4) applyStimulus(65536, 49152, 0);
        waitCycles(3);
        repeat (4) applyStimulus(65536, 49152, 3);
        waitCycles(3);

        repeat (4) applyStimulus(-131072, 131071, 0);
        waitCycles(3);

        freeze = 1'b1;
        repeat (4) applyStimulus(40000, 32768, 0);
        waitCycles(3);
        freeze = 1'b0;
        checkOutput("frozen_ref_hold", longint'(ref_level), 131071);
        checkOutput("pulses_after_freeze", pulseCount, 6);

        // Freeze honoured while still warming up.
        reset = 1'b1;
        modelReset();
        waitCycles(1);
        checkResetState("reset2");
        reset = 1'b0;
        waitCycles(1);
        freeze = 1'b1;
        repeat (4) applyStimulus(20000, 20000, 0);
        waitCycles(3);
        freeze = 1'b0;

        // Reset mid-window discards partial sums.
        repeat (2) applyStimulus(5000, 5000, 0);
        reset = 1'b1;
        modelReset();
        waitCycles(1);
        checkResetState("midreset");
        reset = 1'b0;
        waitCycles(1);
        base = pulseCount;
        repeat (4) applyStimulus(8192, 8192, 0);
        waitCycles(3);
        checkOutput("midreset_pulses", pulseCount - base, 1);

        // Continuous strobes across three windows.
        pulseCycles.delete();
        base = pulseCount;
        for (int i = 0; i < 12; i++) begin
            w = ((i * 7919) % 60000) - 30000;
            applyStimulus(w, w - 1000 * (i % 3), 0);
        end
        waitCycles(4);
        checkOutput("stream_pulses", pulseCount - base, 3);
        if (pulseCycles.size() == 3) begin
            checkOutput("stream_gap1", pulseCycles[1] - pulseCycles[0], 4);
            checkOutput("stream_gap2", pulseCycles[2] - pulseCycles[1], 4);
        end else begin
            checkOutput("stream_pulse_list", pulseCycles.size(), 3);
        end

        for (int i = 0; i < 20 && expQ.size() != 0; i++) waitCycles(1);
        checkOutput("queue_drain", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
